// File: rtl/counter_scheduler.sv
// Round-robin scheduler that time-shares one external counter between requesters needing programmable delays.
// Optional macro COUNTER_SCHEDULER_ABORT_EN lets the owner cancel its transaction by dropping req.
module counter_scheduler #(
   parameter int Size       = 5,
   parameter int Requesters = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [Requesters-1:0]      req,
   input  logic [Requesters*Size-1:0] delay,
   input  logic [Size-1:0]            count,
   output logic                       counter_reset,
   output logic [Requesters-1:0]      grant,
   output logic [Requesters-1:0]      done,
   output logic                       busy
);

   localparam int PtrW = (Requesters > 1) ? $clog2(Requesters) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t                state_q, state_d;
   logic [PtrW-1:0]       ptr_q, ptr_d;
   logic [Size-1:0]       delay_q, delay_d;
   logic [Requesters-1:0] grant_q, grant_d;
   logic [Requesters-1:0] done_q, done_d;
   logic                  counter_reset_q, counter_reset_d;

   logic                  found;
   logic [PtrW-1:0]       sel_idx;
   logic [PtrW-1:0]       cand_idx;
   logic [Size-1:0]       sel_delay;
   logic                  abort;
   int                    cand;

   // Search upward from the slot after the last winner, wrapping at Requesters.
   always_comb begin
      found     = 1'b0;
      sel_idx   = ptr_q;
      cand      = 0;
      cand_idx  = '0;
      sel_delay = '0;
      for (int i = 1; i <= Requesters; i++) begin
         cand = int'(ptr_q) + i;
         if (cand >= Requesters) begin
            cand = cand - Requesters;
         end
         cand_idx = PtrW'(cand);
         if (!found && req[cand_idx]) begin
            found   = 1'b1;
            sel_idx = cand_idx;
         end
      end
      for (int i = 0; i < Requesters; i++) begin
         if (int'(sel_idx) == i) begin
            sel_delay = delay[i*Size +: Size];
         end
      end
   end

`ifdef COUNTER_SCHEDULER_ABORT_EN
   assign abort = ~|(req & grant_q);
`else
   assign abort = 1'b0;
`endif

   always_comb begin
      state_d         = state_q;
      ptr_d           = ptr_q;
      delay_d         = delay_q;
      grant_d         = grant_q;
      done_d          = done_q;
      counter_reset_d = counter_reset_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d          = '0;
               grant_d[sel_idx] = 1'b1;
               delay_d          = sel_delay;
               ptr_d            = sel_idx;
               counter_reset_d  = 1'b0;
               state_d          = RUN;
            end
         end
         RUN: begin
            // Abort wins over a same-cycle match; the pointer stays on the aborted owner.
            if (abort) begin
               grant_d         = '0;
               counter_reset_d = 1'b1;
               state_d         = IDLE;
            end else if (count == delay_q) begin
               done_d          = grant_q;
               counter_reset_d = 1'b1;
               state_d         = DONE;
            end
         end
         DONE: begin
            grant_d = '0;
            done_d  = '0;
            state_d = IDLE;
         end
         default: begin
            grant_d         = '0;
            done_d          = '0;
            counter_reset_d = 1'b1;
            state_d         = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= IDLE;
         ptr_q           <= PtrW'(Requesters - 1);
         delay_q         <= '0;
         grant_q         <= '0;
         done_q          <= '0;
         counter_reset_q <= 1'b1;
      end else begin
         state_q         <= state_d;
         ptr_q           <= ptr_d;
         delay_q         <= delay_d;
         grant_q         <= grant_d;
         done_q          <= done_d;
         counter_reset_q <= counter_reset_d;
      end
   end

   assign counter_reset = counter_reset_q;
   assign grant         = grant_q;
   assign done          = done_q;
   assign busy          = (state_q != IDLE);

endmodule
